vga_clkwiz_reconf_ctrl: RTL

//  AXI4-Lite write/read master that reprograms the clk_wiz pixel clock (DRP register map) for a requested resolution_e.

---
 rtl/vga_clkwiz_reconf_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_clkwiz_reconf_ctrl.sv
// AXI4-Lite master that reprograms the clk_wiz pixel clock for a requested VGA mode,
// then polls the status register until the MMCM reports lock or a timeout expires.
package vga_clkwiz_pkg;
  typedef enum logic [1:0] {
    RES_800_600   = 2'd0,
    RES_1280_1028 = 2'd1,
    RES_1920_1080 = 2'd2,
    RES_640_480   = 2'd3
  } resolution_e;
endpackage

module vga_clkwiz_reconf_ctrl
  import vga_clkwiz_pkg::*;
#(
  parameter int AXI_ADDR_W     = 11,
  parameter int POLL_GAP       = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  req_i,
  input  resolution_e           resolution_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  valid_o,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int         TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         GAP_W     = $clog2(POLL_GAP + 1);
  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_RESP, S_GAP, S_RD_ADDR, S_RD_DATA, S_DONE, S_ERR
  } state_e;

  state_e             r_state;
  state_e             w_next;
  resolution_e        r_mode;
  logic [2:0]         r_step;
  logic               r_aw_done;
  logic               r_w_done;
  logic [TMR_W-1:0]   r_timer;
  logic [GAP_W-1:0]   r_gap;
  logic               r_err;
  logic               r_valid;

  logic               w_supported;
  logic               w_aw_ok;
  logic               w_w_ok;
  logic               w_timeout;
  logic               w_gap_end;
  logic               w_polling;
  logic [31:0]        w_step1_data;
  logic               w_unused;

  always_comb begin
    w_supported  = 1'b0;
    w_step1_data = 32'd0;
    case (resolution_i)
      RES_800_600, RES_1280_1028: w_supported = 1'b1;
      default:                    w_supported = 1'b0;
    endcase
    // Output divider {frac[9:0], int[7:0]} against the 1000 MHz VCO.
    case (r_mode)
      RES_800_600:   w_step1_data = {14'd0, 10'd0,   8'd25};
      RES_1280_1028: w_step1_data = {14'd0, 10'd259, 8'd9};
      default:       w_step1_data = 32'd0;
    endcase
  end

  // Payload is a pure function of registered step/mode, so it is stable while valid is high.
  always_comb begin
    m_axi_awaddr = AXI_ADDR_W'(32'h25C);
    m_axi_wdata  = 32'h0000_0003;
    case (r_step)
      3'd0: begin m_axi_awaddr = AXI_ADDR_W'(32'h200); m_axi_wdata = {6'd0, 10'd0, 8'd10, 8'd1}; end
      3'd1: begin m_axi_awaddr = AXI_ADDR_W'(32'h208); m_axi_wdata = w_step1_data;               end
      3'd2: begin m_axi_awaddr = AXI_ADDR_W'(32'h20C); m_axi_wdata = 32'd0;                      end
      3'd3: begin m_axi_awaddr = AXI_ADDR_W'(32'h210); m_axi_wdata = 32'd50000;                  end
      default: ;
    endcase
  end

  assign m_axi_wstrb  = 4'hF;
  assign m_axi_araddr = AXI_ADDR_W'(32'h004);
  assign w_aw_ok      = r_aw_done | (m_axi_awvalid & m_axi_awready);
  assign w_w_ok       = r_w_done  | (m_axi_wvalid  & m_axi_wready);
  assign w_timeout    = (r_timer == TMR_W'(TIMEOUT_CYCLES));
  assign w_gap_end    = (r_gap == GAP_W'(POLL_GAP - 1));
  assign w_polling    = (r_state == S_GAP) || (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
  assign w_unused     = &{1'b0, m_axi_rdata[31:1]};
  assign err_o        = r_err;
  assign valid_o      = r_valid;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state   <= S_IDLE;
      r_mode    <= RES_800_600;
      r_step    <= 3'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_timer   <= '0;
      r_gap     <= '0;
      r_err     <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_state <= w_next;
      r_gap   <= (r_state == S_GAP) ? r_gap + GAP_W'(1) : '0;
      if (w_polling && !w_timeout) r_timer <= r_timer + TMR_W'(1);
      case (r_state)
        S_IDLE: if (req_i) begin
          r_mode  <= resolution_i;
          r_err   <= 1'b0;
          r_valid <= 1'b0;
          r_step  <= 3'd0;
        end
        S_WR_ADDR: if (w_aw_ok && w_w_ok) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          if (m_axi_awvalid && m_axi_awready) r_aw_done <= 1'b1;
          if (m_axi_wvalid  && m_axi_wready)  r_w_done  <= 1'b1;
        end
        S_WR_RESP: if (m_axi_bvalid) begin
          if (r_step != LAST_STEP) r_step  <= r_step + 3'd1;
          else                     r_timer <= '0;
        end
        S_DONE:  r_valid <= 1'b1;
        S_ERR:   r_err   <= 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (req_i) w_next = w_supported ? S_WR_ADDR : S_ERR;
      S_WR_ADDR: if (w_aw_ok && w_w_ok) w_next = S_WR_RESP;
      S_WR_RESP: if (m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00)    w_next = S_ERR;
        else if (r_step == LAST_STEP) w_next = S_GAP;
        else                          w_next = S_WR_ADDR;
      end
      S_GAP: begin
        if (w_timeout)      w_next = S_ERR;
        else if (w_gap_end) w_next = S_RD_ADDR;
      end
      S_RD_ADDR: if (m_axi_arready) w_next = S_RD_DATA;
      // Timeout is only honoured once the outstanding read has completed.
      S_RD_DATA: if (m_axi_rvalid) begin
        if (m_axi_rresp != 2'b00) w_next = S_ERR;
        else if (m_axi_rdata[0])  w_next = S_DONE;
        else if (w_timeout)       w_next = S_ERR;
        else                      w_next = S_GAP;
      end
      S_DONE, S_ERR: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    done_o        = 1'b0;
    busy_o        = (r_state != S_IDLE);
    case (r_state)
      S_WR_ADDR: begin
        m_axi_awvalid = !r_aw_done;
        m_axi_wvalid  = !r_w_done;
      end
      S_WR_RESP: m_axi_bready  = 1'b1;
      S_RD_ADDR: m_axi_arvalid = 1'b1;
      S_RD_DATA: m_axi_rready  = 1'b1;
      S_DONE:    done_o        = 1'b1;
      default: ;
    endcase
  end

endmodule
